paged_ram_ctrl: RTL and testbench

- Parametrised successor to the single 16x4 RAM page: a multi-page synchronous RAM with its own page register, a ready/valid request port and a backpressured response port.
- Commands cover single reads, single writes, page select and auto-incrementing burst reads.
- Sits between the core's data path and the data RAM, replacing the fixed single-page store.

---
 rtl/paged_ram_ctrl_if.sv | 35 +++
 rtl/paged_ram_ctrl.sv | 162 ++++++++++++++++
 tb/tb_paged_ram_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/paged_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : paged_ram_ctrl_if
// Description : Request / response bundle for paged_ram_ctrl. The master is the
//               requester; the slave is the RAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface paged_ram_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int PAGE_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [PAGE_W-1:0] req_page;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic [PAGE_W-1:0] page;

    modport master (
        output req_valid, req_op, req_addr, req_page, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, page
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_page, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, page
    );
endinterface
`default_nettype wire

// File: rtl/paged_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : paged_ram_ctrl
// Description : Multi-page synchronous RAM with a page register, a ready/valid
//               request port and a backpressured response port. Supports READ,
//               WRITE, SET_PAGE and auto-incrementing BURST reads.
//               Optional feature macro: PAGED_RAM_CARRY_EN - a burst address
//               wrap carries into the page register.
// Revision    : 1.0 - initial release
// ============================================================================
module paged_ram_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int PAGE_W = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    paged_ram_ctrl_if.slave bus
);
    localparam int MEM_AW = PAGE_W + ADDR_W;
    localparam int DEPTH  = 1 << MEM_AW;

    localparam logic [1:0] OP_READ     = 2'd0;
    localparam logic [1:0] OP_WRITE    = 2'd1;
    localparam logic [1:0] OP_SET_PAGE = 2'd2;
    localparam logic [1:0] OP_BURST    = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RSP   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PAGE_W-1:0] page_q, page_d;
    logic [ADDR_W-1:0] addr_q, addr_d;     // address of the word currently presented
    logic [DATA_W-1:0] cnt_q, cnt_d;       // words still to follow the current one
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_last_q, rsp_last_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              req_ready;
    logic              accept;
    logic              rsp_hs;
    logic [ADDR_W-1:0] next_addr;
    logic [PAGE_W-1:0] next_page;
    logic [MEM_AW-1:0] rd_idx;
    logic [DATA_W-1:0] rd_word;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && bus.req_op == OP_READ)  state_d = ST_RSP;
                if (accept && bus.req_op == OP_BURST) state_d = ST_BURST;
            end
            ST_RSP:   if (rsp_hs) state_d = ST_IDLE;
            ST_BURST: if (rsp_hs && rsp_last_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request readiness, accept and response handshake strobes.
    // Reset masks accept so a simultaneous request (including a WRITE) is dropped.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        accept    = bus.req_valid && req_ready && !reset;
        rsp_hs    = rsp_valid_q && bus.rsp_ready;
    end

    // Burst address/page advance and the single RAM read port index
    always_comb begin
        next_addr = addr_q + 1'b1;
`ifdef PAGED_RAM_CARRY_EN
        next_page = page_q + PAGE_W'(addr_q == {ADDR_W{1'b1}});
`else
        next_page = page_q;
`endif
        rd_idx  = accept ? {page_q, bus.req_addr} : {next_page, next_addr};
        rd_word = mem_q[rd_idx];
    end

    // Datapath next-state: response word, burst counters and page register.
    // Everything holds unless a request is accepted or a response handshakes.
    always_comb begin
        page_d      = page_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            case (bus.req_op)
                OP_READ: begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_word;
                    rsp_last_d  = 1'b1;
                end
                OP_SET_PAGE: page_d = bus.req_page;
                OP_BURST: begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_word;
                    rsp_last_d  = (bus.req_wdata == '0);
                    addr_d      = bus.req_addr;
                    cnt_d       = bus.req_wdata;
                end
                default: ;
            endcase
        end else if (rsp_hs) begin
            if (state_q == ST_BURST && !rsp_last_q) begin
                // Fetch the following word in the same cycle so the stream has no bubble
                rsp_data_d = rd_word;
                addr_d     = next_addr;
                page_d     = next_page;
                cnt_d      = cnt_q - 1'b1;
                rsp_last_d = (cnt_q == DATA_W'(1));
            end else begin
                rsp_valid_d = 1'b0;
                rsp_last_d  = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            page_q      <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            page_q      <= page_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (accept && bus.req_op == OP_WRITE)
            mem_q[{page_q, bus.req_addr}] <= bus.req_wdata;
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.page      = page_q;

endmodule
`default_nettype wire

// File: tb/tb_paged_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_paged_ram_ctrl
// Description : Self-checking bench for paged_ram_ctrl. Expected response words
//               go into a scoreboard queue; a monitor compares them on every
//               response handshake. Timing checks are made in the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paged_ram_ctrl;
    localparam logic [1:0] OP_READ     = 2'd0;
    localparam logic [1:0] OP_WRITE    = 2'd1;
    localparam logic [1:0] OP_SET_PAGE = 2'd2;
    localparam logic [1:0] OP_BURST    = 2'd3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [4:0] sb[$];   // {last, data}

    paged_ram_ctrl_if #(.DATA_W(4), .ADDR_W(4), .PAGE_W(4)) bus ();

    paged_ram_ctrl #(.DATA_W(4), .ADDR_W(4), .PAGE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares on every response handshake
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(bus.rsp_data), 32'hDEAD);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                check("rsp_data", 32'(bus.rsp_data), 32'(e[3:0]));
                check("rsp_last", 32'(bus.rsp_last), 32'(e[4]));
            end
        end
    end

    // Drive one request starting #1 after a rising edge; returns #1 after the accept edge
    task automatic issue(input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] p, input logic [3:0] wd);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_page  = p;
        bus.req_wdata = wd;
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        issue(OP_WRITE, a, 4'd0, d);
    endtask

    task automatic setpg(input logic [3:0] p);
        issue(OP_SET_PAGE, 4'd0, p, 4'd0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] exp);
        sb.push_back({1'b1, exp});
        issue(OP_READ, a, 4'd0, 4'd0);
        @(negedge clk);
        check("read_latency", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("read_done", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
        @(posedge clk); #1;
    endtask

    // Present n words with rsp_ready high, checking there is no bubble, then idle
    task automatic stream(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("burst_valid", 32'(bus.rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("burst_end", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = 4'd0;
        bus.req_page  = 4'd0;
        bus.req_wdata = 4'd0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_rsp_last",  32'(bus.rsp_last),  32'd0);
        check("rst_page",      32'(bus.page),      32'd0);
        @(posedge clk); #1;

        // Single write then read in page 0
        wr(4'h5, 4'hA);
        do_read(4'h5, 4'hA);
        check("page_after_read", 32'(bus.page), 32'd0);

        // Page isolation
        setpg(4'd3);
        wr(4'h5, 4'h6);
        setpg(4'd0);
        do_read(4'h5, 4'hA);
        setpg(4'd3);
        do_read(4'h5, 4'h6);
        check("page_is_3", 32'(bus.page), 32'd3);

        // Burst of 4 with rsp_ready held high
        setpg(4'd0);
        for (int i = 0; i < 4; i++) wr(4'(i), 4'(i + 1));
        for (int i = 0; i < 4; i++) sb.push_back({(i == 3), 4'(i + 1)});
        issue(OP_BURST, 4'h0, 4'd0, 4'd3);
        stream(4);

        // Same burst, word 2 stalled for 3 cycles
        for (int i = 0; i < 4; i++) sb.push_back({(i == 3), 4'(i + 1)});
        issue(OP_BURST, 4'h0, 4'd0, 4'd3);
        @(negedge clk);
        check("burst_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_data",  32'(bus.rsp_data),  32'd2);
            check("stall_last",  32'(bus.rsp_last),  32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        stream(3);

        // Burst across the in-page address wrap
        setpg(4'd1);
        wr(4'hF, 4'h9);
        wr(4'h0, 4'h5);
        setpg(4'd2);
        wr(4'h0, 4'h7);
        setpg(4'd1);
        sb.push_back({1'b0, 4'h9});
`ifdef PAGED_RAM_CARRY_EN
        sb.push_back({1'b1, 4'h7});
`else
        sb.push_back({1'b1, 4'h5});
`endif
        issue(OP_BURST, 4'hF, 4'd0, 4'd1);
        stream(2);
`ifdef PAGED_RAM_CARRY_EN
        check("wrap_page", 32'(bus.page), 32'd2);
`else
        check("wrap_page", 32'(bus.page), 32'd1);
`endif

        // Reset while word 1 of a 4-word burst is stalled
        setpg(4'd3);
        wr(4'h6, 4'hC);
        sb.push_back({1'b0, 4'h6});
        issue(OP_BURST, 4'h5, 4'd0, 4'd3);
        @(negedge clk);
        check("burst_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("rst_stall_data", 32'(bus.rsp_data), 32'hC);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_page",      32'(bus.page),      32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        do_read(4'h5, 4'hA);
        setpg(4'd3);
        do_read(4'h5, 4'h6);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
